// File: rtl/imem_pkg.sv
// Shared constants, fault codes and pipeline records for the instruction-memory responder.
package imem_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FAULT_OK       = 2'b00,
      FAULT_MISALIGN = 2'b01,
      FAULT_RANGE    = 2'b10
   } fault_e;

   // The word is captured in stage 1, so later stages carry the instruction instead of the index.
   typedef struct packed {
      logic            valid;
      fault_e          fault;
      logic [XLEN-1:0] instr;
   } stage_t;

   typedef struct packed {
      fault_e          fault;
      logic [XLEN-1:0] instr;
   } rsp_t;

   // Misalignment wins over range; high addresses never alias onto low words.
   function automatic fault_e classify(input logic [XLEN-1:0] addr, input int unsigned depthWords);
      fault_e result;
      if (addr[1:0] != 2'b00) begin
         result = FAULT_MISALIGN;
      end else if ({2'b00, addr[XLEN-1:2]} >= depthWords) begin
         result = FAULT_RANGE;
      end else begin
         result = FAULT_OK;
      end
      return result;
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request and instruction response channels between the fetch stage and the responder.
interface imem_responder_if;
   import imem_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_instr;
   fault_e          rsp_fault;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_instr, rsp_fault
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_instr, rsp_fault
   );
endinterface

// File: rtl/imem_resp_fifo.sv
// First-word fall-through FIFO; the head entry is always visible on o_data.
module imem_resp_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [PW:0]      r_count;
   logic             w_doPush;
   logic             w_doPop;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_doPop  = i_pop && (r_count != '0);
   assign w_doPush = i_push && ((r_count != (PW+1)'(DEPTH)) || w_doPop);

   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rdPtr];
   assign o_count = r_count;
endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: credit-limited fetch pipeline into an in-order response FIFO.
// Defining IMEM_WRITE_PORT_EN adds the wr_en/wr_addr/wr_data program-loading port.
module imem_responder
   import imem_pkg::*;
#(
   parameter int    DEPTH_WORDS     = 256,
   parameter int    LATENCY         = 2,
   parameter int    MAX_OUTSTANDING = 4,
   parameter string INIT_FILE       = "program.hex"
) (
   input  logic            clk,
   input  logic            reset,
`ifdef IMEM_WRITE_PORT_EN
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_addr,
   input  logic [XLEN-1:0] wr_data,
`endif
   imem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   logic [XLEN-1:0] r_mem [DEPTH_WORDS];
   stage_t          r_pipe [LATENCY];
   logic [CW-1:0]   r_credit;

   logic            w_reqReady;
   logic            w_accept;
   logic            w_pop;
   logic            w_rspValid;
   fault_e          w_reqFault;
   logic [XLEN-1:0] w_readWord;
   rsp_t            w_tail;
   rsp_t            w_head;
   logic [CW-1:0]   w_fifoCount;
   logic            w_wrCommit;
   logic [AW-1:0]   w_wrIndex;
   logic [XLEN-1:0] w_wrData;

`ifdef IMEM_WRITE_PORT_EN
   assign w_wrCommit = wr_en && (classify(wr_addr, DEPTH_WORDS) == FAULT_OK);
   assign w_wrIndex  = wr_addr[AW+1:2];
   assign w_wrData   = wr_data;
`else
   assign w_wrCommit = 1'b0;
   assign w_wrIndex  = '0;
   assign w_wrData   = '0;
`endif

   // Plain always so the INIT_FILE image can be placed into the array by the load flow.
   always @(posedge clk) begin
      if (w_wrCommit) begin
         r_mem[w_wrIndex] <= w_wrData;
      end
   end

   // Credit spans pipeline plus FIFO, so accepting never looks at rsp_ready.
   assign w_reqReady    = (r_credit < CW'(MAX_OUTSTANDING));
   assign bus.req_ready = w_reqReady;
   assign w_accept      = bus.req_valid && w_reqReady;
   assign w_reqFault    = classify(bus.req_addr, DEPTH_WORDS);
   assign w_readWord    = (w_reqFault == FAULT_OK) ? r_mem[bus.req_addr[AW+1:2]] : NOP_INSTR;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         r_pipe[0] <= '{valid: w_accept, fault: w_reqFault, instr: w_readWord};
         for (int i = 1; i < LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_credit <= '0;
      end else begin
         case ({w_accept, w_pop})
            2'b10:   r_credit <= r_credit + 1'b1;
            2'b01:   r_credit <= r_credit - 1'b1;
            default: r_credit <= r_credit;
         endcase
      end
   end

   assign w_tail = '{fault: r_pipe[LATENCY-1].fault, instr: r_pipe[LATENCY-1].instr};

   imem_resp_fifo #(
      .WIDTH($bits(rsp_t)),
      .DEPTH(MAX_OUTSTANDING)
   ) u_rspFifo (
      .clk    (clk),
      .reset  (reset),
      .i_push (r_pipe[LATENCY-1].valid),
      .i_data (w_tail),
      .i_pop  (w_pop),
      .o_data (w_head),
      .o_count(w_fifoCount)
   );

   // Outputs read zero while empty so stale FIFO storage never shows after reset.
   assign w_rspValid    = (w_fifoCount != '0);
   assign w_pop         = w_rspValid && bus.rsp_ready;
   assign bus.rsp_valid = w_rspValid;
   assign bus.rsp_instr = w_rspValid ? w_head.instr : '0;
   assign bus.rsp_fault = w_rspValid ? w_head.fault : FAULT_OK;
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed fetch scenarios plus randomized traffic.
module tb_imem_responder;
   import imem_pkg::*;

   localparam int DEPTH  = 256;
   localparam int LAT    = 2;
   localparam int MAXOUT = 4;

   typedef struct {
      logic [31:0] instr;
      logic [1:0]  fault;
      int          readyAt;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   imem_responder_if bus();

`ifdef IMEM_WRITE_PORT_EN
   logic        wr_en   = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
`endif

   imem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY(LAT),
      .MAX_OUTSTANDING(MAXOUT),
      .INIT_FILE("program.hex")
   ) dut (
      .clk(clk),
      .reset(reset),
`ifdef IMEM_WRITE_PORT_EN
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   exp_t        sbQ[$];
   logic [31:0] modelMem [DEPTH];
   int          outstanding = 0;
   int          edgeCount   = 0;
   int          vectors     = 0;
   int          miscompares = 0;
   bit          checking    = 1'b0;

   always @(posedge clk) edgeCount++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference behaviour: word memory, fault rules, NOP substitution.
   function automatic exp_t predict(input logic [31:0] addr);
      exp_t e;
      e.readyAt = 0;
      if (addr % 4 != 0) begin
         e.fault = 2'b01;
         e.instr = 32'h0000_0013;
      end else if (addr / 4 >= DEPTH) begin
         e.fault = 2'b10;
         e.instr = 32'h0000_0013;
      end else begin
         e.fault = 2'b00;
         e.instr = modelMem[int'(addr / 4)];
      end
      return e;
   endfunction

   // Monitor: samples mid-cycle, so handshakes seen here complete at the next rising edge.
   always @(negedge clk) begin
      bit   expValid;
      bit   expReady;
      exp_t e;
      if (reset) begin
         sbQ.delete();
         outstanding = 0;
      end else if (checking) begin
         expValid = 1'b0;
         if (sbQ.size() > 0) expValid = (sbQ[0].readyAt <= edgeCount);
         expReady = (outstanding < MAXOUT);
         checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(expValid));
         checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
         if (expValid) begin
            checkOutput("rsp_instr", bus.rsp_instr, sbQ[0].instr);
            checkOutput("rsp_fault", 32'(bus.rsp_fault), 32'(sbQ[0].fault));
            if (bus.rsp_ready) begin
               sbQ.delete(0);
               outstanding--;
            end
         end
         if (bus.req_valid && expReady) begin
            e = predict(bus.req_addr);
            e.readyAt = edgeCount + 1 + LAT;
            sbQ.push_back(e);
            outstanding++;
         end
      end
`ifdef IMEM_WRITE_PORT_EN
      if (wr_en && wr_addr[1:0] == 2'b00 && (wr_addr >> 2) < DEPTH) begin
         modelMem[int'(wr_addr >> 2)] = wr_data;
      end
`endif
   end

   task automatic applyStimulus(input bit valid, input logic [31:0] addr, input bit rspReady);
      bus.req_valid = valid;
      bus.req_addr  = addr;
      bus.rsp_ready = rspReady;
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      bus.req_valid = 1'b0;
      reset = 1'b1;
      sbQ.delete();
      outstanding = 0;
      #1;
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("reset_rsp_instr", bus.rsp_instr, 32'd0);
      checkOutput("reset_rsp_fault", 32'(bus.rsp_fault), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (sbQ.size() != 0 && budget < 100) begin
         applyStimulus(1'b0, 32'h0, 1'b1);
         budget++;
      end
      if (sbQ.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL drain_timeout: %0d responses pending, expected 0", sbQ.size());
         sbQ.delete();
         outstanding = 0;
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: run exceeded its time limit, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a;
      int          sel;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         modelMem[i]  = $urandom();
         dut.r_mem[i] = modelMem[i];
      end
      #2;
      applyReset();
      checking = 1'b1;

      $display("[TB] single fetch of 0x8");
      applyStimulus(1'b1, 32'h8, 1'b1);
      drain();

      $display("[TB] four stalled fetches saturate credit");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), 1'b0);
      applyStimulus(1'b1, 32'h10, 1'b0);
      repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
      drain();

      $display("[TB] fault classification");
      applyStimulus(1'b1, 32'h6, 1'b1);
      applyStimulus(1'b1, 32'h400, 1'b1);
      applyStimulus(1'b1, 32'h3FC, 1'b1);
      applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
      applyStimulus(1'b1, 32'h401, 1'b1);
      drain();

      $display("[TB] 20 back-to-back fetches");
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'(i * 4), 1'b1);
      drain();

      $display("[TB] reset with fetches in flight");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(32'h40 + i * 4), 1'b0);
      #1;
      applyReset();
      applyStimulus(1'b1, 32'h10, 1'b1);
      drain();

`ifdef IMEM_WRITE_PORT_EN
      $display("[TB] write/read collision on 0x20");
      wr_en   = 1'b1;
      wr_addr = 32'h20;
      wr_data = 32'hDEAD_BEEF;
      applyStimulus(1'b1, 32'h20, 1'b1);
      wr_en = 1'b0;
      applyStimulus(1'b1, 32'h20, 1'b1);
      drain();
`endif

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++) begin
         sel = int'($urandom_range(0, 9));
         if (sel <= 5)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
         else if (sel == 6) a = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
         else if (sel == 7) a = $urandom();
         else if (sel == 8) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 15) * 4);
         else               a = 32'((DEPTH - 1) * 4);
`ifdef IMEM_WRITE_PORT_EN
         wr_en   = ($urandom_range(0, 7) == 0);
         wr_addr = ($urandom_range(0, 3) == 0) ? a : 32'($urandom_range(0, DEPTH - 1) * 4);
         wr_data = $urandom();
`endif
         applyStimulus($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0);
      end
`ifdef IMEM_WRITE_PORT_EN
      wr_en = 1'b0;
`endif
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
